output_buffer_writer: RTL and testbench

- Address-generation stage directly upstream of output_buffer_3x3.
- Accepts conv-layer results as a valid/ready stream, one channel value per beat, in raster order: row, then column, then channel fastest.
- Before each frame, writes zeros into the padded border. Then writes each incoming value to its padded RAM address, so the downstream 3x3 window read sees a zero-padded feature map.

---
 rtl/output_buffer_writer_pkg.sv | 17 +
 rtl/output_buffer_writer_if.sv | 27 ++
 rtl/output_buffer_writer_raster_counter.sv | 76 +++++++
 rtl/output_buffer_writer.sv | 148 ++++++++++++++
 tb/tb_output_buffer_writer.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/output_buffer_writer_pkg.sv
// Shared types and address helpers for the output-buffer write and read sides.
package outbuf_pkg;

   typedef enum logic [1:0] {IDLE, CLEAR, DATA, DONE} wr_state_t;

   // Counter width for a range of n values, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Linear address of padded coordinate (r, c, ch). Channel is the fastest-varying index.
   function automatic int pad_addr(input int r, input int c, input int ch,
                                   input int pad_width, input int out_channels);
      return (r * pad_width + c) * out_channels + ch;
   endfunction

endpackage

// File: rtl/output_buffer_writer_if.sv
// Bundles the upstream stream, the control and the buffer write bus of output_buffer_writer.
interface output_buffer_writer_if #(
   parameter int DATA_WIDTH    = 8,
   parameter int WR_ADDR_WIDTH = 8
);
   logic                     start;
   logic                     in_valid;
   logic                     in_ready;
   logic [DATA_WIDTH-1:0]    in_data;
   logic                     wr_en;
   logic [WR_ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0]    wr_data;
   logic                     is_padding;
   logic                     busy;
   logic                     frame_done;

   // The master is the upstream producer and controller; the slave is the writer.
   modport master (
      output start, in_valid, in_data,
      input  in_ready, wr_en, wr_addr, wr_data, is_padding, busy, frame_done
   );

   modport slave (
      input  start, in_valid, in_data,
      output in_ready, wr_en, wr_addr, wr_data, is_padding, busy, frame_done
   );
endinterface

// File: rtl/output_buffer_writer_raster_counter.sv
// Three-level wrap counter (channel fastest, then column, then row) with a clear and a last flag.
module raster_counter
   import outbuf_pkg::*;
#(
   parameter  int N_CH  = 3,
   parameter  int N_COL = 5,
   parameter  int N_ROW = 5,
   localparam int CH_W  = cnt_width(N_CH),
   localparam int COL_W = cnt_width(N_COL),
   localparam int ROW_W = cnt_width(N_ROW)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [CH_W-1:0]  ch_o,
   output logic [COL_W-1:0] col_o,
   output logic [ROW_W-1:0] row_o,
   output logic             last_o
);
   localparam logic [CH_W-1:0]  CH_MAX  = CH_W'(N_CH - 1);
   localparam logic [COL_W-1:0] COL_MAX = COL_W'(N_COL - 1);
   localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(N_ROW - 1);

   logic [CH_W-1:0]  ch_q,  ch_d;
   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic             ch_last, col_last, row_last;

   assign ch_last  = (ch_q  == CH_MAX);
   assign col_last = (col_q == COL_MAX);
   assign row_last = (row_q == ROW_MAX);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      ch_d  = ch_q;
      col_d = col_q;
      row_d = row_q;
      if (clr_i) begin
         ch_d  = '0;
         col_d = '0;
         row_d = '0;
      end else if (inc_i) begin
         if (!ch_last) begin
            ch_d = ch_q + 1'b1;
         end else begin
            ch_d = '0;
            if (!col_last) begin
               col_d = col_q + 1'b1;
            end else begin
               col_d = '0;
               row_d = row_last ? '0 : row_q + 1'b1;
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments; reset is synchronous, sampled on clk.
   always_ff @(posedge clk) begin
      if (rst) begin
         ch_q  <= '0;
         col_q <= '0;
         row_q <= '0;
      end else begin
         ch_q  <= ch_d;
         col_q <= col_d;
         row_q <= row_d;
      end
   end

   assign ch_o   = ch_q;
   assign col_o  = col_q;
   assign row_o  = row_q;
   assign last_o = ch_last && col_last && row_last;

endmodule

// File: rtl/output_buffer_writer.sv
// Zero-fills the padded border of the output buffer, then writes each streamed value to its padded address.
// Define OUTBUF_WR_RELU_EN to clamp negative (signed) input values to zero before writing.
module output_buffer_writer
   import outbuf_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int OUT_CHANNELS = 3,
   parameter int IN_WIDTH     = 5,
   parameter int IN_HEIGHT    = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   output_buffer_writer_if.slave bus_if
);
   localparam int PAD_WIDTH     = IN_WIDTH + 2;
   localparam int PAD_HEIGHT    = IN_HEIGHT + 2;
   localparam int DEPTH         = PAD_WIDTH * PAD_HEIGHT * OUT_CHANNELS;
   localparam int WR_ADDR_WIDTH = $clog2(DEPTH);
   localparam int CH_W          = cnt_width(OUT_CHANNELS);
   localparam int PC_W          = cnt_width(PAD_WIDTH);
   localparam int PR_W          = cnt_width(PAD_HEIGHT);
   localparam int C_W           = cnt_width(IN_WIDTH);
   localparam int R_W           = cnt_width(IN_HEIGHT);

   localparam logic [PC_W-1:0] PC_LAST = PC_W'(PAD_WIDTH - 1);
   localparam logic [PR_W-1:0] PR_LAST = PR_W'(PAD_HEIGHT - 1);

   wr_state_t                state_q, state_d;
   logic                     wr_en_q, wr_en_d;
   logic [WR_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
   logic                     is_padding_q, is_padding_d;

   logic [CH_W-1:0] clr_ch, dat_ch;
   logic [PC_W-1:0] clr_col;
   logic [PR_W-1:0] clr_row;
   logic [C_W-1:0]  dat_col;
   logic [R_W-1:0]  dat_row;
   logic            clr_last, dat_last, clr_border;
   logic            frame_start, handshake;
   logic [DATA_WIDTH-1:0] data_in;

   assign frame_start = (state_q == IDLE) && bus_if.start;
   assign handshake   = (state_q == DATA) && bus_if.in_valid;
   assign clr_border  = (clr_row == '0) || (clr_row == PR_LAST) ||
                        (clr_col == '0) || (clr_col == PC_LAST);

   raster_counter #(
      .N_CH (OUT_CHANNELS),
      .N_COL(PAD_WIDTH),
      .N_ROW(PAD_HEIGHT)
   ) u_clear_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (frame_start),
      .inc_i (state_q == CLEAR),
      .ch_o  (clr_ch),
      .col_o (clr_col),
      .row_o (clr_row),
      .last_o(clr_last)
   );

   raster_counter #(
      .N_CH (OUT_CHANNELS),
      .N_COL(IN_WIDTH),
      .N_ROW(IN_HEIGHT)
   ) u_data_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (frame_start),
      .inc_i (handshake),
      .ch_o  (dat_ch),
      .col_o (dat_col),
      .row_o (dat_row),
      .last_o(dat_last)
   );

`ifdef OUTBUF_WR_RELU_EN
   assign data_in = bus_if.in_data[DATA_WIDTH-1] ? '0 : bus_if.in_data;
`else
   assign data_in = bus_if.in_data;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         is_padding_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         is_padding_q <= is_padding_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus_if.start)          state_d = CLEAR;
         CLEAR:   if (clr_last)              state_d = DATA;
         DATA:    if (handshake && dat_last) state_d = DONE;
         DONE:                               state_d = IDLE;
         default:                            state_d = IDLE;
      endcase
   end

   // The largest address is DEPTH-1, so narrowing the integer result to WR_ADDR_WIDTH loses nothing.
   always_comb begin
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      is_padding_d = is_padding_q;
      case (state_q)
         CLEAR: begin
            if (clr_border) begin
               wr_en_d      = 1'b1;
               wr_addr_d    = WR_ADDR_WIDTH'(pad_addr(int'(clr_row), int'(clr_col), int'(clr_ch),
                                                      PAD_WIDTH, OUT_CHANNELS));
               wr_data_d    = '0;
               is_padding_d = 1'b1;
            end
         end
         DATA: begin
            if (handshake) begin
               wr_en_d      = 1'b1;
               wr_addr_d    = WR_ADDR_WIDTH'(pad_addr(int'(dat_row) + 1, int'(dat_col) + 1,
                                                      int'(dat_ch), PAD_WIDTH, OUT_CHANNELS));
               wr_data_d    = data_in;
               is_padding_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   assign bus_if.in_ready   = (state_q == DATA);
   assign bus_if.busy       = (state_q == CLEAR) || (state_q == DATA);
   assign bus_if.frame_done = (state_q == DONE);
   assign bus_if.wr_en      = wr_en_q;
   assign bus_if.wr_addr    = wr_addr_q;
   assign bus_if.wr_data    = wr_data_q;
   assign bus_if.is_padding = is_padding_q;

endmodule

// File: tb/tb_output_buffer_writer.sv
// Scoreboard bench for output_buffer_writer on a 5x5x3 map, plus spot-check and ReLU tables.
module tb_output_buffer_writer;
   localparam int DW = 8, OC = 3, IW = 5, IH = 5;
   localparam int PW = IW + 2, PH = IH + 2, AW = 8, BEATS = IW * IH * OC;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          pad;
   } wr_t;

   typedef struct {
      int            beat;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } spot_t;

   typedef struct {
      logic [DW-1:0] din;
      logic [DW-1:0] dout;
   } relu_vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   output_buffer_writer_if #(.DATA_WIDTH(DW), .WR_ADDR_WIDTH(AW)) bus ();

   output_buffer_writer #(
      .DATA_WIDTH  (DW),
      .OUT_CHANNELS(OC),
      .IN_WIDTH    (IW),
      .IN_HEIGHT   (IH)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .bus_if(bus)
   );

   wr_t           exp_q[$];
   wr_t           e;
   spot_t         spots[6];
   relu_vec_t     rtab[4];
   int            checks = 0, errors = 0;
   int            clear_cycles, wr_pulses, pad_pulses, done_pulses, data_idx, first_pad_addr;
   logic [AW-1:0] log_addr[BEATS], ref_addr[BEATS];
   logic [DW-1:0] log_data[BEATS], ref_data[BEATS];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] relu_model(input logic [DW-1:0] d);
`ifdef OUTBUF_WR_RELU_EN
      return d[DW-1] ? '0 : d;
`else
      return d;
`endif
   endfunction

   function automatic logic [AW-1:0] beat_addr(input int b);
      int r, c, ch;
      r  = b / (IW * OC);
      c  = (b / OC) % IW;
      ch = b % OC;
      return AW'(((r + 1) * PW + (c + 1)) * OC + ch);
   endfunction

   function automatic logic [DW-1:0] data_of(input int b, input int mode);
      if (mode == 0) return DW'(b);
      return rtab[b % 4].din;
   endfunction

   // Monitor: every write the DUT issues is popped from the scoreboard and compared.
   always @(negedge clk) begin
      if (bus.busy === 1'b1 && bus.in_ready === 1'b0) clear_cycles++;
      if (bus.frame_done === 1'b1) begin
         done_pulses++;
         check("frame_done_with_last_write", {bus.wr_en, bus.wr_addr}, {1'b1, 8'd122});
      end
      if (bus.wr_en === 1'b1) begin
         wr_pulses++;
         if (bus.is_padding === 1'b1) begin
            pad_pulses++;
            if (first_pad_addr < 0) first_pad_addr = int'(bus.wr_addr);
         end else if (data_idx < BEATS) begin
            log_addr[data_idx] = bus.wr_addr;
            log_data[data_idx] = bus.wr_data;
            data_idx++;
         end
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %0d data %0h, expected no write", bus.wr_addr, bus.wr_data);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", bus.wr_addr, e.addr);
            check("wr_data", bus.wr_data, e.data);
            check("is_padding", bus.is_padding, e.pad);
         end
      end
   end

   task automatic push_clear();
      wr_t w;
      for (int pr = 0; pr < PH; pr++)
         for (int pc = 0; pc < PW; pc++)
            for (int ch = 0; ch < OC; ch++)
               if (pr == 0 || pr == PH - 1 || pc == 0 || pc == PW - 1) begin
                  w.addr = AW'((pr * PW + pc) * OC + ch);
                  w.data = '0;
                  w.pad  = 1'b1;
                  exp_q.push_back(w);
               end
   endtask

   // Called and returns at posedge+1. stop_at>0 leaves the frame after that many handshakes.
   task automatic run_frame(input bit gaps, input int mode, input bit glitch, input int stop_at);
      int  beat = 0, guard = 0, target;
      bit  hs, pulsed = 1'b0;
      wr_t w;
      target         = (stop_at > 0) ? stop_at : BEATS;
      clear_cycles   = 0;
      wr_pulses      = 0;
      pad_pulses     = 0;
      done_pulses    = 0;
      data_idx       = 0;
      first_pad_addr = -1;
      push_clear();
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (glitch) begin
         repeat (20) @(posedge clk);
         #1 bus.start = 1'b1;
         @(posedge clk); #1;
         bus.start = 1'b0;
      end
      while (beat < target && guard < 3000) begin
         bus.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.in_data  = data_of(beat, mode);
         if (glitch && beat == 40 && !pulsed) begin
            bus.start = 1'b1;
            pulsed    = 1'b1;
         end
         @(negedge clk);
         hs = (bus.in_valid === 1'b1) && (bus.in_ready === 1'b1);
         if (hs) begin
            w.addr = beat_addr(beat);
            w.data = relu_model(bus.in_data);
            w.pad  = 1'b0;
            exp_q.push_back(w);
         end
         @(posedge clk); #1;
         bus.start = 1'b0;
         if (hs) beat++;
         guard++;
      end
      bus.in_valid = 1'b0;
      if (beat < target) begin
         checks++;
         errors++;
         $display("FAIL stream_timeout: got %0d beats accepted, expected %0d", beat, target);
      end
      if (stop_at == 0) begin
         repeat (4) @(posedge clk);
         #1;
      end
   endtask

   task automatic frame_summary(input string tag);
      check({tag, "_clear_cycles"}, clear_cycles, 147);
      check({tag, "_pad_writes"}, pad_pulses, 72);
      check({tag, "_total_writes"}, wr_pulses, 147);
      check({tag, "_frame_done_pulses"}, done_pulses, 1);
      check({tag, "_first_pad_addr"}, first_pad_addr, 0);
      check({tag, "_scoreboard_left"}, exp_q.size(), 0);
      check({tag, "_busy_after"}, bus.busy, 1'b0);
   endtask

   initial begin
      int mism;
      spots[0] = '{0, 8'd24, 8'd0};
      spots[1] = '{2, 8'd26, 8'd2};
      spots[2] = '{3, 8'd27, 8'd3};
      spots[3] = '{14, 8'd38, 8'd14};
      spots[4] = '{15, 8'd45, 8'd15};
      spots[5] = '{74, 8'd122, 8'd74};
`ifdef OUTBUF_WR_RELU_EN
      rtab[0] = '{8'h80, 8'h00};
      rtab[3] = '{8'hFF, 8'h00};
`else
      rtab[0] = '{8'h80, 8'h80};
      rtab[3] = '{8'hFF, 8'hFF};
`endif
      rtab[1] = '{8'h7F, 8'h7F};
      rtab[2] = '{8'h00, 8'h00};

      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_wr_en", bus.wr_en, 1'b0);
      check("reset_wr_addr", bus.wr_addr, 8'd0);
      check("reset_wr_data", bus.wr_data, 8'd0);
      check("reset_is_padding", bus.is_padding, 1'b0);
      check("reset_busy", bus.busy, 1'b0);
      check("reset_frame_done", bus.frame_done, 1'b0);
      check("reset_in_ready", bus.in_ready, 1'b0);
      @(posedge clk); #1;

      // Frame 1: continuous stream, data = beat index.
      run_frame(1'b0, 0, 1'b0, 0);
      frame_summary("nogap");
      for (int i = 0; i < 6; i++) begin
         check($sformatf("spot_addr_beat%0d", spots[i].beat), log_addr[spots[i].beat], spots[i].addr);
         check($sformatf("spot_data_beat%0d", spots[i].beat), log_data[spots[i].beat], spots[i].data);
      end
      for (int i = 0; i < BEATS; i++) begin
         ref_addr[i] = log_addr[i];
         ref_data[i] = log_data[i];
      end

      // Frame 2: random gaps plus stray start pulses in CLEAR and DATA.
      run_frame(1'b1, 0, 1'b1, 0);
      frame_summary("gap");
      mism = 0;
      for (int i = 0; i < BEATS; i++)
         if (log_addr[i] !== ref_addr[i] || log_data[i] !== ref_data[i]) mism++;
      check("gap_vs_nogap_mismatches", mism, 0);

      // Frame 3: reset after 30 accepted beats.
      run_frame(1'b0, 0, 1'b0, 30);
      rst = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("midreset_wr_en", bus.wr_en, 1'b0);
      check("midreset_busy", bus.busy, 1'b0);
      check("midreset_in_ready", bus.in_ready, 1'b0);
      check("midreset_no_frame_done", done_pulses, 0);
      exp_q.delete();
      @(posedge clk); #1;

      // Frame 4: fresh frame after reset, ReLU probe data.
      run_frame(1'b0, 1, 1'b0, 0);
      frame_summary("after_reset");
      for (int i = 0; i < 4; i++) begin
         check($sformatf("relu_data_%0h", rtab[i].din), log_data[i], rtab[i].dout);
         check($sformatf("relu_addr_beat%0d", i), log_addr[i], beat_addr(i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
